// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path.
// Samples each bit at mid-bit after a 2-flop synchroniser. Each received byte
// goes into a one-entry output buffer. A stop bit sampled low produces a
// framing_error pulse, and a byte that arrives while the buffer is still full
// produces an overrun pulse.
//
// Output handshake: a byte moves to the consumer in any cycle where
// data_out_valid and data_out_ready are both high (a "fire"). data_out_valid
// stays high and data_out stays stable until that fire happens. Only reset
// can clear the buffer without a fire.
module uart_receiver #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic [1:0] dbg_state
);

    // Baud timing. CLOCKS_PER_BIT must be at least 4 for the mid-bit sampling to work.
    localparam int CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT       = CLOCKS_PER_BIT / 2;
    localparam int CW             = $clog2(CLOCKS_PER_BIT) + 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            ferr_q;
    logic            ovr_q;
    logic            sync1_q;
    logic            sync2_q;
    logic            fire;

    assign fire           = valid_q & data_out_ready;
    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign framing_error  = ferr_q;
    assign overrun        = ovr_q;
    assign dbg_state      = state_q;

    // Two-flop synchroniser. It resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
        end
    end

    // Receive FSM together with the output buffer and the single-cycle flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            // Flags are pulses, so they default low every cycle.
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;

            // The consumer has taken the byte. A delivery later in this
            // cycle can refill the buffer.
            if (fire) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    idx_q <= 3'd0;
                    if (!sync2_q) begin
                        state_q <= ST_START;
                    end
                end

                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        // If the line is back high at mid start bit, the low was a glitch.
                        if (!sync2_q) begin
                            state_q <= ST_DATA;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ST_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        // Bits arrive LSB first, so shifting right leaves the byte LSB-aligned.
                        shift_q <= {sync2_q, shift_q[7:1]};
                        if (idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ST_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        // Going back to IDLE at mid stop bit lets the FSM catch a start edge that follows immediately.
                        state_q <= ST_IDLE;
                        if (sync2_q) begin
                            if (!valid_q || fire) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames for uart_receiver running at 10 clocks per bit.
// Each test pushes the bytes and flags it expects into queues. An independent
// monitor pops those queues whenever the DUT hands over a byte or raises a flag.
`timescale 1ns/1ps
module tb_uart_receiver;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;
    logic [1:0] dbg_state;

    int tests;
    int fails;
    int cyc;
    int start_cyc;
    int rise_cyc;
    int run_len;
    int last_width;
    logic prev_valid;

    logic [7:0] exp_q[$];
    logic [1:0] flag_q[$];   // 1 = framing error, 2 = overrun

    uart_receiver #(
        .CLOCK_FREQ(100),
        .BAUD_RATE (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .framing_error (framing_error),
        .overrun       (overrun),
        .dbg_state     (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on negedge and compares delivered bytes and flags against the queues
    initial begin
        run_len    = 0;
        last_width = 0;
        rise_cyc   = 0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (data_out_valid && !prev_valid) rise_cyc = cyc;
                if (data_out_valid) run_len++;
                else if (run_len > 0) begin
                    last_width = run_len;
                    run_len    = 0;
                end
                if (data_out_valid && data_out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", {24'h0, data_out}, 32'hFFFF_FFFF);
                    end else begin
                        check("byte", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
                    end
                end
                if (framing_error && overrun) begin
                    check("flags_both_high", 32'd1, 32'd0);
                end
                if (framing_error || overrun) begin
                    if (flag_q.size() == 0) begin
                        check("unexpected_flag", {30'h0, overrun, framing_error}, 32'd0);
                    end else begin
                        check("flag", {30'h0, overrun, framing_error}, {30'h0, flag_q.pop_front()});
                    end
                end
            end else begin
                run_len = 0;
            end
            prev_valid = data_out_valid;
        end
    end

    // Driver tasks. Each one starts and ends 1ns after a posedge.
    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int gap);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
        idle(gap);
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        rst            = 1'b0;
        serial_in      = 1'b1;
        data_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_data", {24'h0, data_out}, 32'h0);
        check("rst_valid", {31'h0, data_out_valid}, 32'h0);
        check("rst_flags", {30'h0, overrun, framing_error}, 32'h0);
        check("rst_state", {30'h0, dbg_state}, 32'h0);
        rst = 1'b1;
        idle(5);

        // Test 1: 0xA5 with ready high, checking latency and pulse width
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 20);
        check("t1_latency", rise_cyc - start_cyc, 32'd98);
        check("t1_width", last_width, 32'd1);

        // Test 2: 3-clock glitch, then 0x3C
        serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(20);
        check("t2_glitch_state", {30'h0, dbg_state}, 32'h0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 20);

        // Test 3: bad stop bit on 0x55, then 0x0F
        flag_q.push_back(2'd1);
        send_frame(8'h55, 1'b0, 20);
        check("t3_no_valid", {31'h0, data_out_valid}, 32'h0);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 20);

        // Test 4: ready low, 0x11 then 0x22 back-to-back, giving an overrun
        data_out_ready = 1'b0;
        exp_q.push_back(8'h11);
        flag_q.push_back(2'd2);
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 20);
        check("t4_held_valid", {31'h0, data_out_valid}, 32'h1);
        check("t4_held_data", {24'h0, data_out}, 32'h11);
        data_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_drain_valid", {31'h0, data_out_valid}, 32'h0);
        check("t4_data_hold", {24'h0, data_out}, 32'h11);
        @(posedge clk);
        #1;
        idle(5);

        // Test 5: 0x00, 0xFF, 0x80 back-to-back
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h80);
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'h80, 1'b1, 20);

        // Test 6: reset asserted during data bit 4 of 0xC3, then 0x7E
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        serial_in = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("t6_rst_data", {24'h0, data_out}, 32'h0);
        check("t6_rst_valid", {31'h0, data_out_valid}, 32'h0);
        check("t6_rst_flags", {30'h0, overrun, framing_error}, 32'h0);
        check("t6_rst_state", {30'h0, dbg_state}, 32'h0);
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(20);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 20);

        // Every expected byte and flag must have been consumed
        check("exp_q_empty", exp_q.size(), 32'd0);
        check("flag_q_empty", flag_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, idle high. It is the receive-side counterpart of the transmitter in the io_circuits UART path. It synchronises the asynchronous serial input and samples each bit at mid-bit. Each validated byte is presented on a one-entry valid/ready output buffer, with single-cycle framing-error and overrun flags.

Parameters:
CLOCK_FREQ, 125_000_000, clk frequency in Hz
BAUD_RATE, 115_200, line rate in bits/s; CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer divide), HALF_BIT = CLOCKS_PER_BIT / 2; CLOCKS_PER_BIT >= 4 required

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
serial_in  input  1  asynchronous UART line, idle high
data_out  output  8  received byte, stable while data_out_valid=1
data_out_valid  output  1  byte available in output buffer
data_out_ready  input  1  consumer accepts byte when high with data_out_valid
framing_error  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: completed byte dropped because buffer full

Behaviour:
- Reset, async on rst low, applied immediately regardless of clk: state=IDLE, counters=0, both synchroniser flops=1, shift reg=0, data_out=0x00, data_out_valid=0, framing_error=0, overrun=0. Reset mid-frame abandons the frame; no partial byte is delivered.
- Input path: 2-flop synchroniser; serial_sync is the second flop. All FSM decisions use serial_sync only.
- Bit counter width: $clog2(CLOCKS_PER_BIT)+1. Bit index: 3 bits.
- IDLE: counter=0, index=0. serial_sync==0 -> START.
- START: counter increments each cycle. At counter==HALF_BIT-1:
  - serial_sync==0: counter=0 -> DATA.
  - serial_sync==1: treat as a glitch -> IDLE, no flags.
- DATA: counter increments. At counter==CLOCKS_PER_BIT-1:
  - Sample serial_sync into shift reg: shift right, new bit enters bit 7, so LSB-first arrival ends LSB-aligned.
  - counter=0. Index 7 -> STOP; otherwise index+1.
- STOP: counter increments. At counter==CLOCKS_PER_BIT-1, which is mid stop bit:
  - serial_sync==1: deliver byte (see output buffer).
  - serial_sync==0: framing_error=1 for exactly that cycle; byte discarded; buffer untouched.
  - Either way -> IDLE. Returning at mid stop bit allows resync to an immediately following start edge.
- Output buffer (fire = data_out_valid & data_out_ready):
  - Deliver with buffer empty, or with fire in the same cycle: data_out=shift reg, data_out_valid=1 next cycle.
  - Deliver with data_out_valid=1 and no fire: new byte dropped, data_out unchanged, overrun=1 for one cycle.
  - Fire without deliver: data_out_valid=0 next cycle; data_out holds its value.
  - data_out_valid never drops without fire, except on reset.
- framing_error and overrun are 0 in all other cycles; the two flags are never both 1.
- Latency: data_out_valid rises 2 + HALF_BIT + 9*CLOCKS_PER_BIT + 1 cycles (±1) after the line falling edge.

Test Plan:
Bench uses CLOCK_FREQ=100, BAUD_RATE=10 (CLOCKS_PER_BIT=10, HALF_BIT=5). A frame is 10 bits of 10 clocks each.
1. Frame 0xA5, ready=1 -> data_out=0xA5, data_out_valid high exactly 1 cycle, rising ~98 cycles after start edge; framing_error=0, overrun=0.
2. Line low for 3 clocks then high, followed by a full frame 0x3C -> no output for the glitch; then data_out=0x3C valid; no flags.
3. Frame 0x55 with stop bit driven 0 -> framing_error 1-cycle pulse, data_out_valid stays 0; next frame 0x0F received correctly.
4. ready=0, frames 0x11 then 0x22 back-to-back -> data_out=0x11 valid held; overrun pulse at the second stop sample; data_out stays 0x11. Raise ready -> 0x11 consumed, data_out_valid=0 next cycle.
5. Back-to-back frames 0x00, 0xFF, 0x80 with no idle gap, ready=1 -> three valid pulses carrying 0x00, 0xFF, 0x80 in order; no flags.
6. Assert rst low during data bit 4 of 0xC3 -> all outputs at reset values before the next clk edge; release, send 0x7E -> data_out=0x7E valid, no stale byte.
